genius_fpga_player: RTL and testbench
=====================================

// Module: genius_fpga_player
// PURPOSE
//  Datapath stage driven by the Genius game controller. Generates the pseudo-random colour
//  sequence, plays the first `round` colours on the LEDs, and tracks round progress.
//  Consumes controller enables R1/R2/E1/E3 and returns end_FPGA and win to it.
//  Exposes a read port so the user-check stage can compare user presses against the sequence.
// PARAMETERS
//  MAX_ROUNDS  16          sequence length; reaching it means the game is won (>=2)
//  ON_TICKS    25_000_000  cycles each colour stays lit (>=1)
//  OFF_TICKS   12_500_000  dark gap after each colour (>=1)
// PORTS
//  CLOCK     in   1   single clock, rising edge
//  reset     in   1   synchronous, active-high
//  R1        in   1   game clear: round<=1, idx<=0, FSM->IDLE (aborts GEN/playback)
//  R2        in   1   next round: round<=round+1, saturates at MAX_ROUNDS
//  E1        in   1   setup: LFSR steps every cycle while high; falling edge starts GEN
//  E3        in   1   play enable (level); dropping it aborts playback
//  rd_addr   in   $clog2(MAX_ROUNDS)  sequence index requested by check stage
//  rd_sym    out  2   seq[rd_addr], registered, 1-cycle latency
//  led       out  4   one-hot colour being shown; 0 when dark
//  end_FPGA  out  1   high in DONE, held while E3 high
//  win       out  1   combinational: round == MAX_ROUNDS
//  busy      out  1   high during GEN
//  round     out  $clog2(MAX_ROUNDS+1)  colours played this round
// BEHAVIOUR
//  Reset: FSM=IDLE, round=1, idx=0, tick=0, lfsr=16'hACE1, led=0, end_FPGA=0, rd_sym=0,
//   busy=0; sequence memory contents undefined (not reset).
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1; never zero. Steps while E1=1 or in GEN.
//  FSM IDLE/GEN/ON/OFF/DONE:
//   IDLE: E1 falling edge (E1_q=1,E1=0) -> GEN, wr_ptr=0. Else E3=1 -> ON, idx=0, tick=0.
//   GEN: each cycle seq[wr_ptr]<=lfsr[1:0], wr_ptr++; after MAX_ROUNDS writes -> IDLE.
//     E3 seen in GEN is ignored until IDLE; playback then starts the cycle after GEN ends.
//   ON: led=onehot(seq[idx]); after ON_TICKS cycles -> OFF, tick=0.
//   OFF: led=0; after OFF_TICKS cycles: if idx+1==round -> DONE, else idx++, -> ON.
//   DONE: end_FPGA=1, led=0; E3=0 -> IDLE.
//   ON/OFF with E3=0 -> IDLE next edge, led=0, end_FPGA never asserted.
//  Outputs led/end_FPGA are registered (Moore, from state register).
//  Latency: E3 sampled at edge t -> led lit from t+1; end_FPGA rises at
//   t+1+round*(ON_TICKS+OFF_TICKS).
//  Priority on one edge: reset > R1 > R2 > FSM transitions. R1 and R2 together: R1 wins.
//  R2 at round==MAX_ROUNDS: round unchanged, win stays 1.
//  win is valid in the same cycle R2 is high (reflects pre-increment round).
//  tick counter width = $clog2(max(ON_TICKS,OFF_TICKS)+1); no wrap, cleared on each phase entry.
//  rd_sym reads memory regardless of FSM state; read during GEN returns old or new data
//   (same-address collision undefined).
// STRUCTURE
//  genius_pkg: FSM state enum (3-bit), SYM_W=2, LED_W=4, function onehot4(sym).
//  Sub-module genius_lfsr (16-bit, step enable, fixed seed on reset); rest inline.
//  Sequence memory: MAX_ROUNDS x 2 register array, one write port, one sync read port.
// TESTING  (bench params MAX_ROUNDS=4, ON_TICKS=3, OFF_TICKS=2)
//  1 reset 2 cycles -> led=0, end_FPGA=0, busy=0, round=1, win=0.
//  2 E1=1 x10 cycles then 0 -> busy=1 for exactly 4 cycles; rd_addr 0..3 matches
//    reference LFSR model seq.
//  3 round=1, E3=1 at edge t -> led=onehot(seq[0]) t+1..t+3, led=0 t+4..t+5,
//    end_FPGA=1 at t+6 until E3=0.
//  4 R2 pulsed 3x -> round=4, win=1; 4th R2 -> round stays 4; R1 -> round=1, win=0.
//  5 round=2, E3 dropped at t+2 (mid ON) -> led=0 at t+3, end_FPGA stays 0, FSM=IDLE.
//  6 E3 raised during GEN -> first led lit the cycle after busy falls.

Source files
------------

// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared types and helpers for the Genius sequence player
package genius_pkg;

    localparam int SYM_W = 2;
    localparam int LED_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GEN  = 3'd1,
        ST_ON   = 3'd2,
        ST_OFF  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [LED_W-1:0] onehot4(input logic [SYM_W-1:0] sym);
        logic [LED_W-1:0] one;
        one = {{(LED_W-1){1'b0}}, 1'b1};
        return one << sym;
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// rtl/genius_lfsr.sv - 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) emitting a colour symbol
module genius_lfsr
    import genius_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic             CLOCK,
    input  logic             reset,
    input  logic             step,
    output logic [SYM_W-1:0] sym
);

    logic [15:0] state;

    // Right-shifting Galois form; a non-zero seed can never reach the all-zero lock-up state.
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state <= SEED;
        end else if (step) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign sym = state[SYM_W-1:0];

endmodule

// File: rtl/genius_fpga_player.sv
// rtl/genius_fpga_player.sv - Genius sequence generator, LED playback and round tracking
module genius_fpga_player
    import genius_pkg::*;
#(
    parameter int MAX_ROUNDS = 16,
    parameter int ON_TICKS   = 25_000_000,
    parameter int OFF_TICKS  = 12_500_000,
    localparam int IDX_W     = $clog2(MAX_ROUNDS),
    localparam int ROUND_W   = $clog2(MAX_ROUNDS + 1),
    localparam int TICK_W    = $clog2(((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS) + 1)
) (
    input  logic               CLOCK,
    input  logic               reset,
    input  logic               R1,
    input  logic               R2,
    input  logic               E1,
    input  logic               E3,
    input  logic [IDX_W-1:0]   rd_addr,
    output logic [SYM_W-1:0]   rd_sym,
    output logic [LED_W-1:0]   led,
    output logic               end_FPGA,
    output logic               win,
    output logic               busy,
    output logic [ROUND_W-1:0] round
);

    localparam logic [TICK_W-1:0]  ON_LAST   = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0]  OFF_LAST  = TICK_W'(OFF_TICKS - 1);
    localparam logic [IDX_W-1:0]   PTR_LAST  = IDX_W'(MAX_ROUNDS - 1);
    localparam logic [ROUND_W-1:0] ROUND_MAX = ROUND_W'(MAX_ROUNDS);
    localparam logic [ROUND_W-1:0] ROUND_ONE = ROUND_W'(1);

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [IDX_W-1:0]   wr_ptr, wr_ptr_d;
    logic [TICK_W-1:0]  tick, tick_d;
    logic [LED_W-1:0]   led_d;
    logic               end_d;
    logic               e1_q;
    logic               e1_fall;
    logic               lfsr_step;
    logic [SYM_W-1:0]   lfsr_sym;
    logic [SYM_W-1:0]   seq [MAX_ROUNDS];

    assign e1_fall   = e1_q & ~E1;
    assign lfsr_step = E1 | (state == ST_GEN);
    assign busy      = (state == ST_GEN);
    assign win       = (round == ROUND_MAX);

    genius_lfsr u_lfsr (
        .CLOCK (CLOCK),
        .reset (reset),
        .step  (lfsr_step),
        .sym   (lfsr_sym)
    );

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            wr_ptr   <= '0;
            tick     <= '0;
            e1_q     <= 1'b0;
            led      <= '0;
            end_FPGA <= 1'b0;
            rd_sym   <= '0;
            round    <= ROUND_ONE;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            wr_ptr   <= wr_ptr_d;
            tick     <= tick_d;
            e1_q     <= E1;
            led      <= led_d;
            end_FPGA <= end_d;
            rd_sym   <= seq[rd_addr];
            if (R1) begin
                round <= ROUND_ONE;
            end else if (R2 && (round != ROUND_MAX)) begin
                round <= round + 1'b1;
            end
        end
    end

    // Sequence memory is deliberately left unreset.
    always_ff @(posedge CLOCK) begin
        if (!reset && !R1 && (state == ST_GEN)) begin
            seq[wr_ptr] <= lfsr_sym;
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        wr_ptr_d = wr_ptr;
        tick_d   = tick;
        case (state)
            ST_IDLE: begin
                if (e1_fall) begin
                    state_d  = ST_GEN;
                    wr_ptr_d = '0;
                end else if (E3) begin
                    state_d = ST_ON;
                    idx_d   = '0;
                    tick_d  = '0;
                end
            end
            ST_GEN: begin
                wr_ptr_d = wr_ptr + 1'b1;
                if (wr_ptr == PTR_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ON: begin
                if (!E3) begin
                    state_d = ST_IDLE;
                end else if (tick == ON_LAST) begin
                    state_d = ST_OFF;
                    tick_d  = '0;
                end else begin
                    tick_d = tick + 1'b1;
                end
            end
            ST_OFF: begin
                if (!E3) begin
                    state_d = ST_IDLE;
                end else if (tick == OFF_LAST) begin
                    tick_d = '0;
                    if ((ROUND_W'(idx) + 1'b1) == round) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = ST_ON;
                    end
                end else begin
                    tick_d = tick + 1'b1;
                end
            end
            ST_DONE: begin
                if (!E3) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (R1) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end
    end

    // Outputs are decoded from the next state so they land in registers on the same edge.
    always_comb begin
        led_d = '0;
        end_d = 1'b0;
        case (state_d)
            ST_ON:   led_d = onehot4(seq[idx_d]);
            ST_DONE: end_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_genius_fpga_player.sv
// tb/tb_genius_fpga_player.sv - randomized self-checking bench for genius_fpga_player
module tb_genius_fpga_player;

    localparam int MAXR = 4;
    localparam int ONT  = 3;
    localparam int OFFT = 2;
    localparam int PER  = ONT + OFFT;

    logic       CLOCK = 1'b0;
    logic       reset, R1, R2, E1, E3;
    logic [1:0] rd_addr;
    logic [1:0] rd_sym;
    logic [3:0] led;
    logic       end_FPGA, win, busy;
    logic [2:0] round;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr;
    logic [1:0]  m_seq [MAXR];
    int          m_round;

    genius_fpga_player #(.MAX_ROUNDS(MAXR), .ON_TICKS(ONT), .OFF_TICKS(OFFT)) dut (
        .CLOCK(CLOCK), .reset(reset), .R1(R1), .R2(R2), .E1(E1), .E3(E3),
        .rd_addr(rd_addr), .rd_sym(rd_sym), .led(led), .end_FPGA(end_FPGA),
        .win(win), .busy(busy), .round(round)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(negedge CLOCK);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

    // Expected LED pattern i cycles into playback: each colour lit ONT cycles then OFFT dark.
    function automatic logic [3:0] trace_led(input int i);
        if ((i % PER) < ONT) return onehot(m_seq[i / PER]);
        return 4'b0000;
    endfunction

    task automatic run_gen(input int n, input bit raise_e3);
        E1 = 1'b1;
        repeat (n) begin
            cyc();
            m_lfsr = lfsr_next(m_lfsr);
        end
        E1 = 1'b0;
        for (int k = 0; k < MAXR; k++) begin
            m_seq[k] = m_lfsr[1:0];
            m_lfsr   = lfsr_next(m_lfsr);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            expect_eq("gen_busy", busy, (i < MAXR) ? 1 : 0);
            expect_eq("gen_led", led, (raise_e3 && i == MAXR + 1) ? onehot(m_seq[0]) : 4'b0000);
            if (raise_e3 && i == 1) E3 = 1'b1;
            if (i == MAXR + 1) E3 = 1'b0;
        end
    endtask

    task automatic check_seq();
        for (int k = 0; k < MAXR + 2; k++) begin
            rd_addr = (k < MAXR) ? 2'(k) : 2'($urandom_range(0, MAXR - 1));
            cyc();
            expect_eq("rd_sym", rd_sym, m_seq[rd_addr]);
        end
    endtask

    task automatic set_round(input int r);
        R1 = 1'b1;
        cyc();
        R1 = 1'b0;
        m_round = 1;
        for (int j = 1; j < r; j++) begin
            R2 = 1'b1;
            cyc();
            R2 = 1'b0;
            m_round++;
        end
        expect_eq("round_set", round, m_round);
    endtask

    task automatic run_play(input int drop_at);
        int len;
        len = m_round * PER;
        E3 = 1'b1;
        for (int i = 0; i < len + 2; i++) begin
            cyc();
            if (drop_at >= 0 && i > drop_at) begin
                expect_eq("drop_led", led, 4'b0000);
                expect_eq("drop_end", end_FPGA, 0);
            end else begin
                expect_eq("play_led", led, (i < len) ? trace_led(i) : 4'b0000);
                expect_eq("play_end", end_FPGA, (i >= len) ? 1 : 0);
            end
            if (i == drop_at) E3 = 1'b0;
        end
        E3 = 1'b0;
        cyc();
        expect_eq("exit_end", end_FPGA, 0);
        expect_eq("exit_led", led, 4'b0000);
    endtask

    task automatic play_round(input int drop_at);
        run_play(drop_at);
        if (drop_at >= 0) run_play(-1);
    endtask

    initial begin
        reset = 1'b1; R1 = 1'b0; R2 = 1'b0; E1 = 1'b0; E3 = 1'b0; rd_addr = '0;
        m_lfsr = 16'hACE1;
        m_round = 1;
        cyc();
        cyc();
        expect_eq("rst_led", led, 4'b0000);
        expect_eq("rst_end", end_FPGA, 0);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_round", round, 1);
        expect_eq("rst_win", win, 0);
        reset = 1'b0;

        run_gen(10, 1'b0);
        check_seq();
        play_round(-1);

        set_round(1);
        expect_eq("win_low", win, 0);
        for (int j = 2; j <= MAXR; j++) begin
            R2 = 1'b1;
            cyc();
            R2 = 1'b0;
            expect_eq("r2_step", round, j);
        end
        expect_eq("win_high", win, 1);
        R2 = 1'b1;
        #1;
        expect_eq("win_during_r2", win, 1);
        cyc();
        R2 = 1'b0;
        expect_eq("r2_saturate", round, MAXR);
        R1 = 1'b1;
        R2 = 1'b1;
        cyc();
        R1 = 1'b0;
        R2 = 1'b0;
        expect_eq("r1_wins", round, 1);
        expect_eq("r1_win_low", win, 0);
        m_round = 1;

        set_round(2);
        play_round(1);

        run_gen(int'($urandom_range(1, 8)), 1'b1);
        check_seq();

        repeat (6) begin
            run_gen(int'($urandom_range(1, 20)), 1'b0);
            check_seq();
            set_round(int'($urandom_range(1, MAXR)));
            play_round(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, m_round * PER - 1)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
